// File: rtl/gat_pkg.sv
// Shared GAT attention-path types and constants (softmax, normalizer, aggregator).
package gat_pkg;

    localparam int WOI = 1;
    localparam int WOF = 31;

    localparam int DEF_SM_SUM_DATA_WIDTH = 108;
    localparam int DEF_MAX_NODES         = 168;
    localparam int DEF_NUM_NODE_WIDTH    = $clog2(DEF_MAX_NODES);
    localparam int DEF_DIVISOR_FF_WIDTH  = DEF_NUM_NODE_WIDTH + DEF_SM_SUM_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_WAIT = 3'd1,
        N_REQ  = 3'd2,
        N_WAIT = 3'd3,
        DIV    = 3'd4,
        PUSH   = 3'd5
    } alpha_norm_state_e;

endpackage

// File: rtl/fxp_seq_div.sv
// Sequential restoring divider producing an unsigned Q1.(WQ-1) quotient in 32 cycles.
module fxp_seq_div
    import gat_pkg::*;
#(
    parameter int WN = 108,
    parameter int WD = 108,
    parameter int WQ = WOI + WOF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic [WQ-1:0] quotient,
    output logic          done
);

    localparam int WM = ((WN > WD) ? WN : WD) + 2;

    logic [WM-1:0] ext_n;
    logic [WM-1:0] ext_d;
    logic [WM-1:0] first_rem;
    logic          int_hit;
    logic          sat_hit;
    logic [WD:0]   rem;
    logic [WD:0]   rem_sh;
    logic          bit_hit;
    logic [WD-1:0] div_reg;
    logic [WQ-1:0] q_reg;
    logic [4:0]    iter;
    logic          running;
    logic          zero_flag;
    logic          sat_flag;

    // The integer bit is resolved on the start edge, leaving 31 fraction steps.
    always_comb begin
        ext_n     = WM'(dividend);
        ext_d     = WM'(divisor);
        int_hit   = (ext_n >= ext_d);
        sat_hit   = (ext_n >= (ext_d << 1));
        first_rem = int_hit ? (ext_n - ext_d) : ext_n;
        rem_sh    = rem << 1;
        bit_hit   = (rem_sh >= {1'b0, div_reg});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg   <= '0;
            rem       <= '0;
            q_reg     <= '0;
            iter      <= '0;
            running   <= 1'b0;
            zero_flag <= 1'b0;
            sat_flag  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                div_reg   <= divisor;
                rem       <= (WD+1)'(first_rem);
                q_reg     <= WQ'(int_hit);
                zero_flag <= (divisor == '0);
                sat_flag  <= sat_hit;
                iter      <= '0;
                running   <= 1'b1;
            end else if (running) begin
                rem   <= bit_hit ? (rem_sh - {1'b0, div_reg}) : rem_sh;
                q_reg <= {q_reg[WQ-2:0], bit_hit};
                iter  <= iter + 5'd1;
                if (iter == 5'(WQ - 2)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // A zero divisor wins over saturation, since any dividend is >= 2*0.
    assign quotient = zero_flag ? '0 : (sat_flag ? '1 : q_reg);

endmodule

// File: rtl/alpha_normalizer.sv
// Softmax normalizer: divides each subgraph's exp scores by its exp sum into Q1.31 alphas.
// FIFO handshake: a rd_vld pulse pops the head, whose dout is valid while rd_vld is high; wr_vld pushes only when full is low.
module alpha_normalizer
    import gat_pkg::*;
#(
    parameter int SM_DATA_WIDTH       = 108,
    parameter int SM_SUM_DATA_WIDTH   = DEF_SM_SUM_DATA_WIDTH,
    parameter int ALPHA_DATA_WIDTH    = WOI + WOF,
    parameter int MAX_NODES           = DEF_MAX_NODES,
    localparam int NUM_NODE_WIDTH     = $clog2(MAX_NODES),
    localparam int DIVISOR_FF_WIDTH   = NUM_NODE_WIDTH + SM_SUM_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SM_DATA_WIDTH-1:0]    dividend_ff_dout,
    input  logic                        dividend_ff_empty,
    output logic                        dividend_ff_rd_vld,
    input  logic [DIVISOR_FF_WIDTH-1:0] divisor_ff_dout,
    input  logic                        divisor_ff_empty,
    output logic                        divisor_ff_rd_vld,
    output logic [ALPHA_DATA_WIDTH-1:0] alpha_ff_din,
    output logic                        alpha_ff_wr_vld,
    input  logic                        alpha_ff_full,
    output logic                        subgraph_done,
    output logic                        busy,
    output logic [2:0]                  dbg_state
);

    localparam logic [NUM_NODE_WIDTH-1:0] ONE = NUM_NODE_WIDTH'(1);

    alpha_norm_state_e              state;
    logic [NUM_NODE_WIDTH-1:0]      num_node_reg;
    logic [NUM_NODE_WIDTH-1:0]      cnt;
    logic [SM_SUM_DATA_WIDTH-1:0]   sum_reg;
    logic                           div_start;
    logic                           div_done;
    logic [ALPHA_DATA_WIDTH-1:0]    div_quotient;

    assign div_start = (state == N_WAIT);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    fxp_seq_div #(
        .WN (SM_DATA_WIDTH),
        .WD (SM_SUM_DATA_WIDTH),
        .WQ (ALPHA_DATA_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend_ff_dout),
        .divisor  (sum_reg),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            num_node_reg       <= '0;
            cnt                <= '0;
            sum_reg            <= '0;
            dividend_ff_rd_vld <= 1'b0;
            divisor_ff_rd_vld  <= 1'b0;
            alpha_ff_din       <= '0;
            alpha_ff_wr_vld    <= 1'b0;
            subgraph_done      <= 1'b0;
        end else begin
            dividend_ff_rd_vld <= 1'b0;
            divisor_ff_rd_vld  <= 1'b0;
            alpha_ff_wr_vld    <= 1'b0;
            subgraph_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (!divisor_ff_empty) begin
                        divisor_ff_rd_vld <= 1'b1;
                        state             <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    num_node_reg <= divisor_ff_dout[DIVISOR_FF_WIDTH-1 -: NUM_NODE_WIDTH];
                    sum_reg      <= divisor_ff_dout[SM_SUM_DATA_WIDTH-1:0];
                    cnt          <= '0;
                    // An empty subgraph produces nothing, not even a done pulse.
                    if (divisor_ff_dout[DIVISOR_FF_WIDTH-1 -: NUM_NODE_WIDTH] == '0)
                        state <= IDLE;
                    else
                        state <= N_REQ;
                end
                N_REQ: begin
                    if (!dividend_ff_empty) begin
                        dividend_ff_rd_vld <= 1'b1;
                        state              <= N_WAIT;
                    end
                end
                N_WAIT: state <= DIV;
                DIV: begin
                    if (div_done) begin
                        alpha_ff_din <= div_quotient;
                        state        <= PUSH;
                    end
                end
                PUSH: begin
                    if (!alpha_ff_full) begin
                        alpha_ff_wr_vld <= 1'b1;
                        if (cnt == num_node_reg - ONE) begin
                            subgraph_done <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            cnt   <= cnt + ONE;
                            state <= N_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_normalizer.sv
// Directed bench for alpha_normalizer with 16-bit scores and sums.
module tb_alpha_normalizer;
  import gat_pkg::*;

  localparam int SMW  = 16;
  localparam int SUMW = 16;
  localparam int AW   = 32;
  localparam int MN   = 168;
  localparam int NNW  = $clog2(MN);
  localparam int DFW  = NNW + SUMW;

  logic           clk;
  logic           rst;
  logic [SMW-1:0] dividend_ff_dout;
  logic           dividend_ff_empty;
  logic           dividend_ff_rd_vld;
  logic [DFW-1:0] divisor_ff_dout;
  logic           divisor_ff_empty;
  logic           divisor_ff_rd_vld;
  logic [AW-1:0]  alpha_ff_din;
  logic           alpha_ff_wr_vld;
  logic           alpha_ff_full;
  logic           subgraph_done;
  logic           busy;
  logic [2:0]     dbg_state;

  alpha_normalizer #(
    .SM_DATA_WIDTH     (SMW),
    .SM_SUM_DATA_WIDTH (SUMW),
    .ALPHA_DATA_WIDTH  (AW),
    .MAX_NODES         (MN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .dividend_ff_dout   (dividend_ff_dout),
    .dividend_ff_empty  (dividend_ff_empty),
    .dividend_ff_rd_vld (dividend_ff_rd_vld),
    .divisor_ff_dout    (divisor_ff_dout),
    .divisor_ff_empty   (divisor_ff_empty),
    .divisor_ff_rd_vld  (divisor_ff_rd_vld),
    .alpha_ff_din       (alpha_ff_din),
    .alpha_ff_wr_vld    (alpha_ff_wr_vld),
    .alpha_ff_full      (alpha_ff_full),
    .subgraph_done      (subgraph_done),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO models (written by tasks, popped on clock) ----------------
  logic [SMW-1:0] dvd_mem [0:63];
  logic [DFW-1:0] div_mem [0:63];
  int dvd_wr = 0;
  int div_wr = 0;
  int dvd_rd = 0;
  int div_rd = 0;
  int cyc    = 0;

  assign dividend_ff_empty = (dvd_rd == dvd_wr);
  assign divisor_ff_empty  = (div_rd == div_wr);
  assign dividend_ff_dout  = dvd_mem[dvd_rd % 64];
  assign divisor_ff_dout   = div_mem[div_rd % 64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dividend_ff_rd_vld) dvd_rd <= dvd_rd + 1;
    if (divisor_ff_rd_vld)  div_rd <= div_rd + 1;
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] got_q[$];
  bit            got_done[$];
  int            got_cyc[$];
  int            got_lat[$];
  logic [AW-1:0] exp_q[$];
  int   nreq_cyc  = 0;
  int   busy_cyc  = 0;
  int   dvd_reads = 0;
  int   proto_err = 0;
  logic [2:0] prev_state = 3'd0;

  always @(negedge clk) begin
    prev_state <= dbg_state;
    if (dbg_state == N_REQ && prev_state != N_REQ) nreq_cyc <= cyc;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (dividend_ff_rd_vld) dvd_reads <= dvd_reads + 1;
    if ((dividend_ff_rd_vld && divisor_ff_rd_vld) ||
        (dividend_ff_rd_vld && dividend_ff_empty) ||
        (divisor_ff_rd_vld && divisor_ff_empty) ||
        (alpha_ff_wr_vld && alpha_ff_full))
      proto_err <= proto_err + 1;
    if (alpha_ff_wr_vld) begin
      got_q.push_back(alpha_ff_din);
      got_done.push_back(subgraph_done);
      got_cyc.push_back(cyc);
      got_lat.push_back(cyc - nreq_cyc);
    end
  end

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_div(input int nn, input int sum);
    logic [NNW-1:0]  n_f;
    logic [SUMW-1:0] s_f;
    n_f = nn[NNW-1:0];
    s_f = sum[SUMW-1:0];
    div_mem[div_wr % 64] = {n_f, s_f};
    div_wr = div_wr + 1;
  endtask

  task automatic push_dvd(input int v);
    dvd_mem[dvd_wr % 64] = v[SMW-1:0];
    dvd_wr = dvd_wr + 1;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!(dbg_state == IDLE && div_rd == div_wr && dvd_rd == dvd_wr && !alpha_ff_wr_vld) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 3000);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dividend_ff_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_dvd_rd: got %b want 0", dividend_ff_rd_vld); end
    checks++; if (divisor_ff_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_div_rd: got %b want 0", divisor_ff_rd_vld); end
    checks++; if (alpha_ff_wr_vld !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", alpha_ff_wr_vld); end
    checks++; if (alpha_ff_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h want 0", alpha_ff_din); end
    checks++; if (subgraph_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", subgraph_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int base;
    bit ok;
    logic [AW-1:0] e;
    base = got_q.size();
    tick();
    push_div(1, 'h1000);
    push_dvd('h0400);
    exp_q.push_back(32'h2000_0000);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy want idle"); end
    checks++;
    if (got_q.size() != base + 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", got_q.size() - base);
    end else begin
      e = exp_q.pop_front();
      checks++; if (got_q[base] !== e) begin errors++; $display("FAIL single_alpha: got %h want %h", got_q[base], e); end
      checks++; if (got_done[base] !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", got_done[base]); end
      checks++; if (got_lat[base] != 35) begin errors++; $display("FAIL single_latency: got %0d want 35", got_lat[base]); end
    end
    exp_q.delete();
  endtask

  task automatic test_ratios();
    int base;
    bit ok;
    logic [AW-1:0] e;
    bit exp_done [6];
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    base = got_q.size();
    tick();
    push_div(3, 3);
    push_dvd(1); push_dvd(1); push_dvd(1);
    push_div(1, 3); push_dvd(3);
    push_div(1, 3); push_dvd(6);
    push_div(1, 3); push_dvd(5);
    exp_q.push_back(32'h2AAA_AAAA);
    exp_q.push_back(32'h2AAA_AAAA);
    exp_q.push_back(32'h2AAA_AAAA);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hD555_5555);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ratios_timeout: got busy want idle"); end
    checks++;
    if (got_q.size() != base + 6) begin
      errors++; $display("FAIL ratios_count: got %0d want 6", got_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front();
        checks++; if (got_q[base+i] !== e) begin errors++; $display("FAIL ratios_alpha[%0d]: got %h want %h", i, got_q[base+i], e); end
        checks++; if (got_done[base+i] !== exp_done[i]) begin errors++; $display("FAIL ratios_done[%0d]: got %b want %b", i, got_done[base+i], exp_done[i]); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_zero();
    int base, b_busy, b_rd;
    bit ok;
    base = got_q.size(); b_busy = busy_cyc; b_rd = dvd_reads;
    tick();
    push_div(0, 'h7777);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_nodes_timeout: got busy want idle"); end
    checks++; if (got_q.size() != base) begin errors++; $display("FAIL zero_nodes_writes: got %0d want 0", got_q.size() - base); end
    checks++; if (dvd_reads != b_rd) begin errors++; $display("FAIL zero_nodes_reads: got %0d want 0", dvd_reads - b_rd); end
    checks++; if (busy_cyc - b_busy != 1) begin errors++; $display("FAIL zero_nodes_busy: got %0d want 1", busy_cyc - b_busy); end

    base = got_q.size(); b_rd = dvd_reads;
    tick();
    push_div(1, 0); push_dvd('h0050);
    push_div(0, 'h1234);
    push_div(1, 'h1000); push_dvd('h0800);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_sum_timeout: got busy want idle"); end
    checks++; if (dvd_reads - b_rd != 2) begin errors++; $display("FAIL zero_sum_reads: got %0d want 2", dvd_reads - b_rd); end
    checks++;
    if (got_q.size() != base + 2) begin
      errors++; $display("FAIL zero_sum_count: got %0d want 2", got_q.size() - base);
    end else begin
      checks++; if (got_q[base] !== 32'h0) begin errors++; $display("FAIL zero_sum_alpha: got %h want 00000000", got_q[base]); end
      checks++; if (got_q[base+1] !== 32'h4000_0000) begin errors++; $display("FAIL zero_skip_alpha: got %h want 40000000", got_q[base+1]); end
      checks++; if (got_done[base] !== 1'b1 || got_done[base+1] !== 1'b1) begin errors++; $display("FAIL zero_sum_done: got %b%b want 11", got_done[base], got_done[base+1]); end
    end
  endtask

  task automatic test_full();
    int base, n, rel;
    bit ok, stable;
    base = got_q.size();
    tick();
    alpha_ff_full = 1'b1;
    push_div(1, 'h1000); push_dvd('h0C00);
    n = 0;
    @(negedge clk);
    while (dbg_state != PUSH && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL full_reach_push: got state %0d want %0d", dbg_state, PUSH); end
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (alpha_ff_wr_vld !== 1'b0 || alpha_ff_din !== 32'h6000_0000 || dbg_state != PUSH) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL full_hold: got wr=%b din=%h want wr=0 din=60000000", alpha_ff_wr_vld, alpha_ff_din); end
    checks++; if (got_q.size() != base) begin errors++; $display("FAIL full_early_write: got %0d want 0", got_q.size() - base); end
    tick();
    alpha_ff_full = 1'b0;
    rel = cyc;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got busy want idle"); end
    checks++;
    if (got_q.size() != base + 1) begin
      errors++; $display("FAIL full_count: got %0d want 1", got_q.size() - base);
    end else begin
      checks++; if (got_q[base] !== 32'h6000_0000) begin errors++; $display("FAIL full_alpha: got %h want 60000000", got_q[base]); end
      checks++; if (got_cyc[base] != rel + 1) begin errors++; $display("FAIL full_release_timing: got %0d want %0d", got_cyc[base], rel + 1); end
    end
  endtask

  task automatic test_stall();
    int base, n, b_rd;
    bit ok, stall_ok;
    base = got_q.size();
    tick();
    push_div(2, 4); push_dvd(1);
    n = 0;
    @(negedge clk);
    while (got_q.size() < base + 1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL stall_first: got %0d writes want 1", got_q.size() - base); end
    b_rd = dvd_reads;
    stall_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dbg_state != N_REQ || dividend_ff_rd_vld !== 1'b0) stall_ok = 1'b0;
    end
    checks++; if (!stall_ok) begin errors++; $display("FAIL stall_hold: got state %0d rd=%b want %0d rd=0", dbg_state, dividend_ff_rd_vld, N_REQ); end
    checks++; if (dvd_reads != b_rd) begin errors++; $display("FAIL stall_reads: got %0d want 0", dvd_reads - b_rd); end
    tick();
    push_dvd(3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got busy want idle"); end
    checks++;
    if (got_q.size() != base + 2) begin
      errors++; $display("FAIL stall_count: got %0d want 2", got_q.size() - base);
    end else begin
      checks++; if (got_q[base] !== 32'h2000_0000 || got_done[base] !== 1'b0) begin errors++; $display("FAIL stall_first_alpha: got %h/%b want 20000000/0", got_q[base], got_done[base]); end
      checks++; if (got_q[base+1] !== 32'h6000_0000 || got_done[base+1] !== 1'b1) begin errors++; $display("FAIL stall_second_alpha: got %h/%b want 60000000/1", got_q[base+1], got_done[base+1]); end
    end
  endtask

  task automatic test_rst_mid();
    int base, n;
    bit ok;
    base = got_q.size();
    tick();
    push_div(1, 'h1000); push_dvd('h0400);
    n = 0;
    @(negedge clk);
    while (dbg_state != DIV && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL rst_reach_div: got state %0d want %0d", dbg_state, DIV); end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got busy=%b state=%0d want 0/0", busy, dbg_state); end
    checks++;
    if (dividend_ff_rd_vld !== 1'b0 || divisor_ff_rd_vld !== 1'b0 || alpha_ff_wr_vld !== 1'b0 ||
        alpha_ff_din !== 32'h0 || subgraph_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got din=%h wr=%b want all 0", alpha_ff_din, alpha_ff_wr_vld);
    end
    tick();
    rst = 1'b0;
    tick();
    push_div(1, 'h1000); push_dvd('h0800);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_timeout: got busy want idle"); end
    checks++;
    if (got_q.size() != base + 1) begin
      errors++; $display("FAIL rst_after_count: got %0d want 1", got_q.size() - base);
    end else begin
      checks++; if (got_q[base] !== 32'h4000_0000) begin errors++; $display("FAIL rst_after_alpha: got %h want 40000000", got_q[base]); end
    end
  endtask

  task automatic final_report();
    checks++; if (proto_err != 0) begin errors++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    rst           = 1'b1;
    alpha_ff_full = 1'b0;
    test_reset();
    test_single();
    test_ratios();
    test_zero();
    test_full();
    test_stall();
    test_rst_mid();
    final_report();
  end

endmodule
